// File: rtl/uop_pkg.sv
// uop_pkg: shared layout of the execute-stage micro-op word.
// Field offsets are functions of the register-index width so the stage can be
// re-parametrised without editing the decode. LSB-first layout:
//   idx_a | idx_b | sel_inp | adr_wr_back | idx_dest | kind |
//   flags_w | mem_cmd | mem_en | carry_mask | alu_f
package uop_pkg;

  localparam int OFF_IDX_A = 0;

  // kind bit value marking a memory-address op
  localparam logic KIND_MEM = 1'b1;

  // upper two idx_dest bits select the MAR on a memory-address op
  localparam logic [1:0] MAR_DEST_HI = 2'b00;

  function automatic int off_idx_b(int r);       return r;         endfunction
  function automatic int off_sel_inp(int r);     return 2*r;       endfunction
  function automatic int off_adr_wr_back(int r); return 2*r + 1;   endfunction
  function automatic int off_idx_dest(int r);    return 2*r + 2;   endfunction
  function automatic int off_kind(int r);        return 3*r + 2;   endfunction
  function automatic int off_flags_w(int r);     return 3*r + 3;   endfunction
  function automatic int off_mem_cmd(int r);     return 3*r + 4;   endfunction
  function automatic int off_mem_en(int r);      return 3*r + 5;   endfunction
  function automatic int off_carry_mask(int r);  return 3*r + 6;   endfunction
  function automatic int off_alu_f(int r);       return 3*r + 7;   endfunction

  function automatic int uop_width(int r, int a);
    return 3*r + 7 + a;
  endfunction

endpackage

// File: rtl/uop_skid_buf.sv
// uop_skid_buf: 2-entry skid buffer (main + skid register) with valid/ready.
// in_ready is driven straight from the skid-valid flop, so downstream stall
// logic never reaches the upstream ready.
// Ports:
//   clk, a_rst (async, active-low), flush (sync, drops both entries and the
//   current input), in_valid/in_ready/in_data (upstream), pop (consume main
//   this cycle, only meaningful while out_valid), out_valid/out_data (main).
module uop_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         a_rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         pop,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  logic         main_v;
  logic         skid_v;
  logic [W-1:0] main_d;
  logic [W-1:0] skid_d;
  logic         accept;

  assign in_ready  = ~skid_v;
  assign accept    = in_valid & ~skid_v;
  assign out_valid = main_v;
  assign out_data  = main_d;

  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_d <= '0;
      skid_d <= '0;
    end else if (flush) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (pop) begin
      // skid is older than anything arriving now, so it goes first
      if (skid_v) begin
        main_d <= skid_d;
        skid_v <= 1'b0;
      end else if (accept) begin
        main_d <= in_data;
      end else begin
        main_v <= 1'b0;
      end
    end else if (accept) begin
      if (!main_v) begin
        main_v <= 1'b1;
        main_d <= in_data;
      end else begin
        skid_v <= 1'b1;
        skid_d <= in_data;
      end
    end
  end

endmodule

// File: rtl/uop_exec_stage.sv
// uop_exec_stage: execute-stage micro-op register between the scheduler and
// the ALU / register-file / MAR datapath.
// Ports:
//   clk, a_rst (async, active-low), flush, stop
//   in_valid/in_ready/in_uop/in_temp/in_ctx : op intake (skid buffered)
//   home_ctx_wr/home_ctx_in                 : home context register load
//   mem_ack                                 : one memory request completed
//   ex_valid, t16, ex_ctx, field outputs    : held op (fields ungated)
//   reg_wr, flags_w, mar_wr, mem_rq_width, mem_rq, ex_home_mem : strobes,
//     gated by ex_valid & ~stall; mem_rq_cmd is ungated
//   mem_outst, mem_err                      : outstanding count, sticky error
module uop_exec_stage
  import uop_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int REG_IDX_W = 3,
  parameter int ALU_F_W   = 4,
  parameter int CTX_W     = 1,
  parameter int MEM_OUTST = 2,
  parameter int UOP_W     = uop_width(REG_IDX_W, ALU_F_W)
) (
  input  logic                 clk,
  input  logic                 a_rst,
  input  logic                 flush,
  input  logic                 stop,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [UOP_W-1:0]     in_uop,
  input  logic [DATA_W-1:0]    in_temp,
  input  logic [CTX_W-1:0]     in_ctx,
  input  logic                 home_ctx_wr,
  input  logic [CTX_W-1:0]     home_ctx_in,
  input  logic                 mem_ack,
  output logic                 ex_valid,
  output logic [DATA_W-1:0]    t16,
  output logic [CTX_W-1:0]     ex_ctx,
  output logic [REG_IDX_W-1:0] idx_a,
  output logic [REG_IDX_W-1:0] idx_b,
  output logic [REG_IDX_W-1:0] idx_dest,
  output logic                 sel_inp,
  output logic                 adr_wr_back,
  output logic                 carry_mask,
  output logic [ALU_F_W-1:0]   alu_f,
  output logic                 reg_wr,
  output logic                 flags_w,
  output logic                 mar_wr,
  output logic                 mem_rq_width,
  output logic                 mem_rq_cmd,
  output logic                 mem_rq,
  output logic                 ex_home_mem,
  output logic [2:0]           mem_outst,
  output logic                 mem_err
);

  localparam int R     = REG_IDX_W;
  localparam int PAY_W = UOP_W + DATA_W + CTX_W;

  logic [PAY_W-1:0] in_pay;
  logic [PAY_W-1:0] ex_pay;
  logic [UOP_W-1:0] ex_uop;
  logic [CTX_W-1:0] home_ctx;
  logic             kind;
  logic             flags_b;
  logic             mem_cmd_b;
  logic             mem_en_b;
  logic             mem_op;
  logic             mem_block;
  logic             stall;
  logic             advance;

  assign in_pay = {in_uop, in_temp, in_ctx};

  uop_skid_buf #(.W(PAY_W)) u_skid (
    .clk       (clk),
    .a_rst     (a_rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_pay),
    .pop       (advance),
    .out_valid (ex_valid),
    .out_data  (ex_pay)
  );

  assign {ex_uop, t16, ex_ctx} = ex_pay;

  assign idx_a       = ex_uop[OFF_IDX_A +: R];
  assign idx_b       = ex_uop[off_idx_b(R) +: R];
  assign sel_inp     = ex_uop[off_sel_inp(R)];
  assign adr_wr_back = ex_uop[off_adr_wr_back(R)];
  assign idx_dest    = ex_uop[off_idx_dest(R) +: R];
  assign kind        = ex_uop[off_kind(R)];
  assign flags_b     = ex_uop[off_flags_w(R)];
  assign mem_cmd_b   = ex_uop[off_mem_cmd(R)];
  assign mem_en_b    = ex_uop[off_mem_en(R)];
  assign carry_mask  = ex_uop[off_carry_mask(R)];
  assign alu_f       = ex_uop[off_alu_f(R) +: ALU_F_W];

  // Block on the registered count only: an ack this cycle frees a slot next cycle.
  assign mem_op    = mem_cmd_b | mem_en_b;
  assign mem_block = ex_valid & mem_op & (mem_outst == 3'(MEM_OUTST));
  assign stall     = stop | mem_block;
  assign advance   = ex_valid & ~stall;

  assign reg_wr       = advance & (kind != KIND_MEM);
  assign mar_wr       = advance & (kind == KIND_MEM) & (idx_dest[R-1:R-2] == MAR_DEST_HI);
  assign mem_rq_width = mar_wr & idx_dest[0];
  assign flags_w      = advance & flags_b;
  assign mem_rq       = advance & mem_op;
  assign mem_rq_cmd   = mem_cmd_b;
  assign ex_home_mem  = mem_rq & (ex_ctx == home_ctx);

  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      mem_outst <= 3'd0;
      mem_err   <= 1'b0;
    end else if (mem_rq & ~mem_ack) begin
      mem_outst <= mem_outst + 3'd1;
    end else if (mem_ack & ~mem_rq) begin
      if (mem_outst == 3'd0) mem_err   <= 1'b1;
      else                   mem_outst <= mem_outst - 3'd1;
    end
  end

  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst)                   home_ctx <= '0;
    else if (home_ctx_wr & ~stop) home_ctx <= home_ctx_in;
  end

endmodule

// File: tb/tb_uop_exec_stage.sv
module tb_uop_exec_stage;

  localparam int UW = 20;
  localparam int MO = 2;

  logic        clk, a_rst, flush, stop, in_valid, in_ready;
  logic [19:0] in_uop;
  logic [15:0] in_temp;
  logic        in_ctx, home_ctx_wr, home_ctx_in, mem_ack;
  logic        ex_valid, ex_ctx;
  logic [15:0] t16;
  logic [2:0]  idx_a, idx_b, idx_dest, mem_outst;
  logic        sel_inp, adr_wr_back, carry_mask;
  logic [3:0]  alu_f;
  logic        reg_wr, flags_w, mar_wr, mem_rq_width, mem_rq_cmd, mem_rq, ex_home_mem, mem_err;

  uop_exec_stage dut (
    .clk(clk), .a_rst(a_rst), .flush(flush), .stop(stop),
    .in_valid(in_valid), .in_ready(in_ready), .in_uop(in_uop), .in_temp(in_temp), .in_ctx(in_ctx),
    .home_ctx_wr(home_ctx_wr), .home_ctx_in(home_ctx_in), .mem_ack(mem_ack),
    .ex_valid(ex_valid), .t16(t16), .ex_ctx(ex_ctx),
    .idx_a(idx_a), .idx_b(idx_b), .idx_dest(idx_dest),
    .sel_inp(sel_inp), .adr_wr_back(adr_wr_back), .carry_mask(carry_mask), .alu_f(alu_f),
    .reg_wr(reg_wr), .flags_w(flags_w), .mar_wr(mar_wr), .mem_rq_width(mem_rq_width),
    .mem_rq_cmd(mem_rq_cmd), .mem_rq(mem_rq), .ex_home_mem(ex_home_mem),
    .mem_outst(mem_outst), .mem_err(mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // reference model: the stage is a 2-deep FIFO of ops plus a request counter
  typedef struct {
    logic [19:0] uop;
    logic [15:0] temp;
    logic        ctx;
  } op_t;

  op_t q[$];
  int  m_cnt;
  bit  m_err;
  bit  m_home;
  int  n_vec;
  int  n_bad;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit m_is_mem(op_t f);
    return f.uop[13] | f.uop[14];
  endfunction

  function automatic bit m_go();
    op_t f;
    if (q.size() == 0) return 1'b0;
    f = q[0];
    if (stop) return 1'b0;
    if (m_is_mem(f) && m_cnt == MO) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_check();
    op_t f;
    bit  ev, go, mar;
    ev = (q.size() > 0);
    f  = '{uop: '0, temp: '0, ctx: 1'b0};
    if (ev) f = q[0];
    go  = m_go();
    mar = go && f.uop[11] && (f.uop[10:9] == 2'b00);
    chk("ex_valid", ex_valid, ev);
    chk("in_ready", in_ready, q.size() < 2);
    chk("reg_wr", reg_wr, go & ~f.uop[11]);
    chk("mar_wr", mar_wr, mar);
    chk("mem_rq_width", mem_rq_width, mar & f.uop[8]);
    chk("flags_w", flags_w, go & f.uop[12]);
    chk("mem_rq", mem_rq, go & m_is_mem(f));
    chk("ex_home_mem", ex_home_mem, go & m_is_mem(f) & (f.ctx == m_home));
    chk("mem_outst", mem_outst, m_cnt);
    chk("mem_err", mem_err, m_err);
    if (ev) begin
      chk("t16", t16, f.temp);
      chk("ex_ctx", ex_ctx, f.ctx);
      chk("idx_a", idx_a, f.uop[2:0]);
      chk("idx_b", idx_b, f.uop[5:3]);
      chk("sel_inp", sel_inp, f.uop[6]);
      chk("adr_wr_back", adr_wr_back, f.uop[7]);
      chk("idx_dest", idx_dest, f.uop[10:8]);
      chk("mem_rq_cmd", mem_rq_cmd, f.uop[13]);
      chk("carry_mask", carry_mask, f.uop[15]);
      chk("alu_f", alu_f, f.uop[19:16]);
    end
  endtask

  task automatic model_update();
    bit go, rq, rdy;
    go  = m_go();
    rq  = go && m_is_mem(q[0]);
    rdy = (q.size() < 2);
    if (rq && !mem_ack) m_cnt++;
    else if (mem_ack && !rq) begin
      if (m_cnt == 0) m_err = 1'b1;
      else            m_cnt--;
    end
    if (home_ctx_wr && !stop) m_home = home_ctx_in;
    if (flush) q.delete();
    else begin
      if (go) void'(q.pop_front());
      if (in_valid && rdy) q.push_back('{uop: in_uop, temp: in_temp, ctx: in_ctx});
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_cnt  = 0;
    m_err  = 1'b0;
    m_home = 1'b0;
  endtask

  task automatic drive(bit iv, logic [19:0] u, logic [15:0] t, bit c,
                       bit st, bit fl, bit ack, bit hw, bit hc);
    in_valid    = iv;
    in_uop      = u;
    in_temp     = t;
    in_ctx      = c;
    stop        = st;
    flush       = fl;
    mem_ack     = ack;
    home_ctx_wr = hw;
    home_ctx_in = hc;
    #1;
  endtask

  // check the current cycle against the model, then clock it
  task automatic step();
    model_check();
    @(posedge clk);
    model_update();
    #1;
  endtask

  typedef struct {
    bit          iv, st, fl, ack;
    logic [19:0] uop;
    logic [15:0] temp;
    bit          e_ev, e_rdy, e_regwr, e_rq, e_err;
    logic [15:0] e_t16;
    logic [2:0]  e_cnt;
  } vec_t;

  localparam logic [19:0] OP_A  = 20'h00001;
  localparam logic [19:0] OP_B  = 20'h00002;
  localparam logic [19:0] OP_C  = 20'h00003;
  localparam logic [19:0] OP_M  = 20'h04900;  // mem_en, kind, dest=001
  localparam logic [19:0] OP_MC = 20'h06800;  // mem_cmd, mem_en, kind, dest=000

  vec_t tbl[26];
  int   saved_cnt;

  initial begin
    n_vec = 0;
    n_bad = 0;
    model_reset();
    a_rst = 1'b0;
    drive(0, '0, '0, 0, 0, 0, 0, 0, 0);

    tbl[0]  = '{0,0,0,0, 20'h00000, 16'h0000, 0,1,0,0,0, 16'h0000, 3'd0};
    tbl[1]  = '{1,0,0,0, 20'h00123, 16'h1234, 0,1,0,0,0, 16'h0000, 3'd0};
    tbl[2]  = '{0,0,0,0, 20'h00000, 16'h0000, 1,1,1,0,0, 16'h1234, 3'd0};
    tbl[3]  = '{0,0,0,0, 20'h00000, 16'h0000, 0,1,0,0,0, 16'h0000, 3'd0};
    tbl[4]  = '{1,0,0,0, OP_A,      16'h00A1, 0,1,0,0,0, 16'h0000, 3'd0};
    tbl[5]  = '{1,1,0,0, OP_B,      16'h00B2, 1,1,0,0,0, 16'h00A1, 3'd0};
    tbl[6]  = '{1,1,0,0, OP_C,      16'h00C3, 1,0,0,0,0, 16'h00A1, 3'd0};
    tbl[7]  = '{1,0,0,0, OP_C,      16'h00C3, 1,0,1,0,0, 16'h00A1, 3'd0};
    tbl[8]  = '{1,0,0,0, OP_C,      16'h00C3, 1,1,1,0,0, 16'h00B2, 3'd0};
    tbl[9]  = '{0,0,0,0, 20'h00000, 16'h0000, 1,1,1,0,0, 16'h00C3, 3'd0};
    tbl[10] = '{0,0,0,0, 20'h00000, 16'h0000, 0,1,0,0,0, 16'h0000, 3'd0};
    tbl[11] = '{1,0,0,0, OP_M,      16'h0101, 0,1,0,0,0, 16'h0000, 3'd0};
    tbl[12] = '{1,0,0,0, OP_M,      16'h0102, 1,1,0,1,0, 16'h0101, 3'd0};
    tbl[13] = '{1,0,0,0, OP_M,      16'h0103, 1,1,0,1,0, 16'h0102, 3'd1};
    tbl[14] = '{0,0,0,0, 20'h00000, 16'h0000, 1,1,0,0,0, 16'h0103, 3'd2};
    tbl[15] = '{0,0,0,0, 20'h00000, 16'h0000, 1,1,0,0,0, 16'h0103, 3'd2};
    tbl[16] = '{0,0,0,1, 20'h00000, 16'h0000, 1,1,0,0,0, 16'h0103, 3'd2};
    tbl[17] = '{0,0,0,0, 20'h00000, 16'h0000, 1,1,0,1,0, 16'h0103, 3'd1};
    tbl[18] = '{0,0,0,0, 20'h00000, 16'h0000, 0,1,0,0,0, 16'h0000, 3'd2};
    tbl[19] = '{0,0,0,1, 20'h00000, 16'h0000, 0,1,0,0,0, 16'h0000, 3'd2};
    tbl[20] = '{1,0,0,0, OP_MC,     16'h0104, 0,1,0,0,0, 16'h0000, 3'd1};
    tbl[21] = '{0,0,0,1, 20'h00000, 16'h0000, 1,1,0,1,0, 16'h0104, 3'd1};
    tbl[22] = '{0,0,0,0, 20'h00000, 16'h0000, 0,1,0,0,0, 16'h0000, 3'd1};
    tbl[23] = '{0,0,0,1, 20'h00000, 16'h0000, 0,1,0,0,0, 16'h0000, 3'd1};
    tbl[24] = '{0,0,0,1, 20'h00000, 16'h0000, 0,1,0,0,0, 16'h0000, 3'd0};
    tbl[25] = '{0,0,0,0, 20'h00000, 16'h0000, 0,1,0,0,1, 16'h0000, 3'd0};

    // reset values while a_rst is held low
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ex_valid", ex_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_t16", t16, 0);
    chk("rst_idx_dest", idx_dest, 0);
    chk("rst_mem_outst", mem_outst, 0);
    chk("rst_strobes", {reg_wr, mar_wr, mem_rq, flags_w, mem_err}, 0);
    a_rst = 1'b1;

    // directed table
    for (int i = 0; i < 26; i++) begin
      drive(tbl[i].iv, tbl[i].uop, tbl[i].temp, 0, tbl[i].st, tbl[i].fl, tbl[i].ack, 0, 0);
      chk($sformatf("tbl%0d_ev", i), ex_valid, tbl[i].e_ev);
      chk($sformatf("tbl%0d_rdy", i), in_ready, tbl[i].e_rdy);
      chk($sformatf("tbl%0d_reg_wr", i), reg_wr, tbl[i].e_regwr);
      chk($sformatf("tbl%0d_mem_rq", i), mem_rq, tbl[i].e_rq);
      chk($sformatf("tbl%0d_cnt", i), mem_outst, tbl[i].e_cnt);
      chk($sformatf("tbl%0d_err", i), mem_err, tbl[i].e_err);
      if (tbl[i].e_ev) chk($sformatf("tbl%0d_t16", i), t16, tbl[i].e_t16);
      step();
    end

    // home context: ops from ctx 1 then ctx 0
    drive(0, '0, '0, 0, 0, 0, 0, 1, 1);          step();
    drive(1, OP_M, 16'h0201, 1, 0, 0, 0, 0, 0);  step();
    drive(1, OP_M, 16'h0202, 0, 0, 0, 0, 0, 0);
    chk("home_mem_ctx1", ex_home_mem, 1);
    step();
    drive(0, '0, '0, 0, 0, 0, 0, 0, 0);
    chk("home_mem_ctx0", ex_home_mem, 0);
    chk("home_mem_ctx0_rq", mem_rq, 1);
    step();
    drive(0, '0, '0, 0, 0, 0, 1, 1, 0);          step();  // stop low: home reloads to 0
    drive(0, '0, '0, 0, 1, 0, 1, 1, 1);          step();  // stop high: home write ignored

    // skid full, then flush
    drive(1, OP_M, 16'h0301, 0, 1, 0, 0, 0, 0);  step();
    drive(1, OP_MC, 16'h0302, 0, 1, 0, 0, 0, 0); step();
    saved_cnt = m_cnt;
    drive(1, OP_A, 16'h0303, 0, 1, 1, 0, 0, 0);
    chk("flush_full_rdy", in_ready, 0);
    chk("flush_full_ev", ex_valid, 1);
    chk("flush_no_strobe", {reg_wr, mar_wr, mem_rq}, 0);
    step();
    drive(0, '0, '0, 0, 0, 0, 0, 0, 0);
    chk("flush_empty_ev", ex_valid, 0);
    chk("flush_empty_rdy", in_ready, 1);
    chk("flush_cnt_kept", mem_outst, 3'(saved_cnt));
    step();

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 2) != 0, 20'($urandom()), 16'($urandom()), 1'($urandom()),
            $urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0,
            $urandom_range(0, 2) == 0 && m_cnt > 0,
            $urandom_range(0, 9) == 0, 1'($urandom()));
      step();
    end

    // asynchronous reset mid-operation, then a stray ack
    drive(1, OP_M, 16'h0401, 0, 0, 0, 0, 0, 0); step();
    drive(1, OP_M, 16'h0402, 0, 1, 0, 0, 0, 0); step();
    drive(1, OP_M, 16'h0403, 0, 1, 0, 0, 0, 0);
    #2;
    a_rst = 1'b0;
    #1;
    model_reset();
    chk("arst_ex_valid", ex_valid, 0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_mem_outst", mem_outst, 0);
    chk("arst_mem_err", mem_err, 0);
    @(posedge clk);
    #1;
    a_rst = 1'b1;
    drive(0, '0, '0, 0, 0, 0, 1, 0, 0); step();
    drive(0, '0, '0, 0, 0, 0, 0, 0, 0);
    chk("post_rst_ack_err", mem_err, 1);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/uop_exec_stage.md
Name: uop_exec_stage

Overview:
- Parametrised execute-stage micro-op register for the core pipeline. It sits between the scheduler and the ALU/register-file/MAR datapath.
- Accepts a micro-op plus its temporary operand through a valid/ready handshake and buffers it in a 2-entry skid buffer.
- Decodes the held micro-op into datapath strobes and issues memory requests, subject to an outstanding-request limit.
- Generalises the single-op latch to configurable widths, N scheduler contexts, backpressure and memory flow control.

Parameters:
- DATA_W, 16, width of temporary operand.
- REG_IDX_W, 3, register index width (>=2).
- ALU_F_W, 4, ALU function code width.
- CTX_W, 1, scheduler context id width (2**CTX_W contexts).
- MEM_OUTST, 2, maximum outstanding memory requests (1..7).
- UOP_W, 3*REG_IDX_W+7+ALU_F_W (20 at defaults), derived; do not override.

Ports:
- clk  in  1  clock
- a_rst  in  1  asynchronous active-low reset
- flush  in  1  synchronous: drop all buffered ops
- stop  in  1  external stall
- in_valid  in  1  op offered
- in_ready  out  1  stage can accept
- in_uop  in  UOP_W  micro-op
- in_temp  in  DATA_W  temporary operand, already selected by the scheduler
- in_ctx  in  CTX_W  context issuing the op
- home_ctx_wr  in  1  load home context register
- home_ctx_in  in  CTX_W  new home context
- mem_ack  in  1  one outstanding request completed
- ex_valid  out  1  op held in main register
- t16  out  DATA_W  temporary operand of held op
- ex_ctx  out  CTX_W  context of held op
- idx_a, idx_b, idx_dest  out  REG_IDX_W  register fields
- sel_inp, adr_wr_back, carry_mask  out  1  pass-through bits
- alu_f  out  ALU_F_W  ALU function
- reg_wr, flags_w, mar_wr, mem_rq_width, mem_rq_cmd, mem_rq  out  1  strobes
- ex_home_mem  out  1  memory request from the home context
- mem_outst  out  3  outstanding request count
- mem_err  out  1  sticky: ack received with count 0

Behaviour:
- uop field layout, LSB first:
  - idx_a[R], idx_b[R], sel_inp, adr_wr_back, idx_dest[R]
  - kind (1 = memory-address op)
  - flags_w, mem_cmd, mem_en, carry_mask
  - alu_f[ALU_F_W]
- Reset values:
  - main/skid valid 0, uop 0, temp 0, ctx 0
  - home_ctx 0, mem_outst 0, mem_err 0
  - all strobes 0; in_ready 1
- in_ready = ~skid_valid (registered source, no combinational path from stop).
- stall = stop | mem_block.
  - mem_block = ex_valid & (mem_cmd|mem_en) & (mem_outst==MEM_OUTST).
  - A same-cycle mem_ack does not unblock.
- advance = ex_valid & ~stall.
- Skid rules, per cycle, with accept = in_valid & in_ready:
  - accept & (~ex_valid | advance) & ~skid_valid -> main loads input.
  - accept & ex_valid & ~advance -> skid loads input.
  - advance & skid_valid -> main loads skid; skid empties.
  - advance & ~skid_valid & ~accept -> main empties.
  - Ordering is strictly FIFO; no op is lost or duplicated.
- Decode (combinational from main register; every strobe is ANDed with ex_valid & ~stall):
  - reg_wr = ~kind.
  - mar_wr = kind & idx_dest[R-1:R-2]==0.
  - mem_rq_width = mar_wr & idx_dest[0].
  - flags_w = flags_w bit.
  - mem_rq = mem_cmd|mem_en.
  - mem_rq_cmd = mem_cmd bit (ungated).
  - ex_home_mem = mem_rq & (ex_ctx==home_ctx).
  - Field outputs are ungated.
- mem_outst:
  - +1 on mem_rq, -1 on mem_ack, unchanged when both occur.
  - ack at 0: count stays 0 and mem_err sets; mem_err clears only on reset.
- home_ctx: loads on home_ctx_wr when ~stop; held while stop is high.
- flush:
  - Clears main and skid valid next cycle; the input that cycle is dropped.
  - mem_outst and home_ctx are unaffected.
  - Strobes are still gated by the current-cycle state.
- Reset mid-operation: asynchronous clear to reset values; pending acks afterwards raise mem_err.
- Latency: an accepted op appears on the outputs the next cycle when unstalled.

Decomposition:
- Package uop_pkg holds:
  - bit-offset localparams for every uop field, derived from REG_IDX_W/ALU_F_W
  - KIND_MEM
  - the MAR destination encoding (upper idx_dest bits 0)
- Sub-module uop_skid_buf (parametric payload width, 2-entry, valid/ready) holds the payload {uop, temp, ctx}.
- Decode and counter logic stay in the top module.

Test Plan:
- Reset, then in_valid with uop=20'h0_0_1_2_3 (reg op), temp=16'h1234 -> next cycle ex_valid=1, t16=1234, reg_wr=1, mar_wr=0, idx_a=3.
- Back-to-back ops A,B,C with stop high for 2 cycles after A -> B goes to skid, in_ready=0, C held; release -> order A,B,C, one strobe each.
- MEM_OUTST=2: three mem ops with no ack -> mem_rq pulses twice, third op holds, mem_outst=2; one ack -> third issues, count stays 2.
- mem_ack and mem_rq in the same cycle at count 1 -> count stays 1; ack at count 0 -> mem_err=1, count 0.
- home_ctx_wr=1 with home_ctx_in=1, then mem ops from ctx 1 and ctx 0 -> ex_home_mem=1 then 0.
- Skid full (main+skid valid) and flush -> both empty next cycle, no strobes, mem_outst unchanged.
